// File: rtl/sd_block_server_if.sv
`default_nettype none
// ============================================================================
// Module      : sd_block_server_if
// Description : Sector request / buffer bus between a disk consumer (master)
//               and the block server (slave).
// Revision    : 1.0 - initial release
// ============================================================================
interface sd_block_server_if;
  logic [31:0] sd_lba;
  logic        sd_rd;
  logic        sd_wr;
  logic        sd_ack;
  logic [8:0]  sd_buff_addr;
  logic [7:0]  sd_buff_dout;
  logic        sd_buff_wr;
  logic [7:0]  sd_buff_din;

  modport master (
    output sd_lba, sd_rd, sd_wr, sd_buff_din,
    input  sd_ack, sd_buff_addr, sd_buff_dout, sd_buff_wr
  );

  modport slave (
    input  sd_lba, sd_rd, sd_wr, sd_buff_din,
    output sd_ack, sd_buff_addr, sd_buff_dout, sd_buff_wr
  );
endinterface
`default_nettype wire

// File: rtl/sd_block_server.sv
`default_nettype none
// ============================================================================
// Module      : sd_block_server
// Description : Host-side responder for the sd_* sector protocol. Runs the
//               sd_ack handshake, streams 512-byte sectors through the
//               sd_buff_* port, backs them with a byte-wide image store and
//               publishes mount notifications.
// Revision    : 1.0 - initial release
// ============================================================================
module sd_block_server #(
  parameter int ACK_DELAY = 4
) (
  input  logic             clk_sys,
  input  logic             reset_n,
  sd_block_server_if.slave sd,
  output logic [40:0]      img_addr,
  output logic             img_rd,
  output logic             img_wr,
  output logic [7:0]       img_dout,
  input  logic [7:0]       img_din,
  input  logic             img_ready,
  input  logic             mount_strobe,
  input  logic [63:0]      mount_size,
  input  logic             mount_readonly,
  output logic             img_mounted,
  output logic [63:0]      img_size,
  output logic             img_readonly,
  output logic             busy
);

  localparam logic [7:0] DELAY_LOAD = 8'(ACK_DELAY - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    DELAY     = 3'd1,
    RD_FETCH  = 3'd2,
    RD_PUSH   = 3'd3,
    WR_ADDR   = 3'd4,
    WR_SAMPLE = 3'd5,
    WR_STORE  = 3'd6,
    DONE      = 3'd7
  } state_t;

  state_t      state;
  state_t      state_nx;

  logic [31:0] lba;
  logic        is_read;
  logic [8:0]  offset;
  logic [7:0]  delay_cnt;
  logic [7:0]  data;

  logic        mount_pending;
  logic [63:0] shadow_size;
  logic        shadow_ro;

  logic        in_range;
  logic        apply_mount;
  logic        accept;
  logic        last_byte;
  logic        store_skip;

  // Sector end address computed in 64 bits so lba 0xFFFFFFFF cannot overflow.
  assign in_range    = ({23'd0, lba, 9'd0} + 64'd512) <= img_size;
  // A pending mount is applied when the FSM is (or is about to be) idle; an
  // idle request waits one cycle behind a pending mount.
  assign apply_mount = mount_pending && ((state == IDLE) || (state == DONE));
  assign accept      = (state == IDLE) && !mount_pending && (sd.sd_rd || sd.sd_wr);
  assign last_byte   = (offset == 9'd511);
  assign store_skip  = !in_range || img_readonly;

  assign sd.sd_buff_addr = offset;
  assign sd.sd_buff_dout = data;
  assign img_addr        = {lba, offset};
  assign img_dout        = data;
  assign busy            = (state != IDLE);

  // State register.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nx;
  end

  // Next-state decode and per-state handshake/store strobes.
  always_comb begin
    state_nx      = state;
    img_rd        = 1'b0;
    img_wr        = 1'b0;
    sd.sd_ack     = 1'b0;
    sd.sd_buff_wr = 1'b0;
    case (state)
      IDLE: begin
        if (accept) state_nx = DELAY;
      end
      DELAY: begin
        if (delay_cnt == 8'd0) state_nx = is_read ? RD_FETCH : WR_ADDR;
      end
      RD_FETCH: begin
        sd.sd_ack = 1'b1;
        img_rd    = in_range;
        if (!in_range || img_ready) state_nx = RD_PUSH;
      end
      RD_PUSH: begin
        sd.sd_ack     = 1'b1;
        sd.sd_buff_wr = 1'b1;
        state_nx      = last_byte ? DONE : RD_FETCH;
      end
      WR_ADDR: begin
        sd.sd_ack = 1'b1;
        state_nx  = WR_SAMPLE;
      end
      WR_SAMPLE: begin
        sd.sd_ack = 1'b1;
        state_nx  = WR_STORE;
      end
      WR_STORE: begin
        sd.sd_ack = 1'b1;
        img_wr    = !store_skip;
        if (store_skip || img_ready) state_nx = last_byte ? DONE : WR_ADDR;
      end
      DONE: begin
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Transfer datapath: request latch, ack delay, byte offset and data byte.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      lba       <= 32'd0;
      is_read   <= 1'b0;
      offset    <= 9'd0;
      delay_cnt <= 8'd0;
      data      <= 8'd0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            lba       <= sd.sd_lba;
            is_read   <= sd.sd_rd;
            offset    <= 9'd0;
            delay_cnt <= DELAY_LOAD;
          end
        end
        DELAY: begin
          if (delay_cnt != 8'd0) delay_cnt <= delay_cnt - 8'd1;
        end
        RD_FETCH: begin
          if (!in_range)      data <= 8'h00;
          else if (img_ready) data <= img_din;
        end
        RD_PUSH: begin
          offset <= offset + 9'd1;
        end
        WR_SAMPLE: begin
          // The consumer's RAM registers its output, so the byte for the
          // address presented in WR_ADDR is only valid during this cycle.
          data <= sd.sd_buff_din;
        end
        WR_STORE: begin
          if (store_skip || img_ready) offset <= offset + 9'd1;
        end
        default: ;
      endcase
    end
  end

  // Mount bookkeeping: shadow the latest strobe, publish it only while idle.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      mount_pending <= 1'b0;
      shadow_size   <= 64'd0;
      shadow_ro     <= 1'b0;
      img_size      <= 64'd0;
      img_readonly  <= 1'b0;
      img_mounted   <= 1'b0;
    end else begin
      img_mounted <= apply_mount;
      if (apply_mount) begin
        img_size      <= shadow_size;
        img_readonly  <= shadow_ro;
        mount_pending <= 1'b0;
      end
      // A strobe in the same cycle as an apply stays pending for next time.
      if (mount_strobe) begin
        mount_pending <= 1'b1;
        shadow_size   <= mount_size;
        shadow_ro     <= mount_readonly;
      end
    end
  end

endmodule
`default_nettype wire
